// File: rtl/n_bit_seq_divmod.sv
// Sequential restoring divider with quotient/modulus outputs, signed/unsigned
// modes, valid/ready handshakes on both sides and result status flags.
module n_bit_seq_divmod #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  input  logic         signed_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] modulus,
  output logic         zero_flag,
  output logic         negative_flag,
  output logic         overflow_flag,
  output logic         carry_flag
);

  localparam int CW = (N > 2) ? $clog2(N) : 1;
  localparam logic [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, next_state;

  logic [CW-1:0] cnt;
  logic [N-1:0]  work_q, dvs_mag, rem;
  logic          q_neg, r_neg, sm_r;

  logic          accept, div_zero, sgn_ovf;
  logic [N-1:0]  dvd_abs, dvs_abs;
  logic [N:0]    rem_sh, diff;
  logic          take;
  logic [N-1:0]  res_q, res_r;
  logic          res_ovf, res_sm, load;

  assign accept   = in_valid && (state == IDLE);
  assign div_zero = (divisor == '0);
  assign sgn_ovf  = signed_mode && (dividend == MIN_NEG) && (divisor == '1);
  assign dvd_abs  = (signed_mode && dividend[N-1]) ? -dividend : dividend;
  assign dvs_abs  = (signed_mode && divisor[N-1])  ? -divisor  : divisor;

  // The remainder register stays below the divisor, so N bits hold it; the
  // shifted value and the trial difference need N+1. A set diff[N] means borrow.
  assign rem_sh = {rem, work_q[N-1]};
  assign diff   = rem_sh - {1'b0, dvs_mag};
  assign take   = !diff[N];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (accept) next_state = (div_zero || sgn_ovf) ? DONE : CALC;
      CALC: if (cnt == CW'(N-1)) next_state = FIX;
      FIX:  next_state = DONE;
      DONE: if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_comb begin
    res_q   = '0;
    res_r   = '0;
    res_ovf = 1'b0;
    res_sm  = sm_r;
    load    = 1'b0;
    if (accept && div_zero) begin
      res_q   = '1;
      res_r   = dividend;
      res_ovf = 1'b1;
      res_sm  = signed_mode;
      load    = 1'b1;
    end else if (accept && sgn_ovf) begin
      res_q   = dividend;
      res_ovf = 1'b1;
      res_sm  = signed_mode;
      load    = 1'b1;
    end else if (state == FIX) begin
      res_q = q_neg ? -work_q : work_q;
      res_r = r_neg ? -rem : rem;
      load  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt           <= '0;
      work_q        <= '0;
      dvs_mag       <= '0;
      rem           <= '0;
      q_neg         <= 1'b0;
      r_neg         <= 1'b0;
      sm_r          <= 1'b0;
      quotient      <= '0;
      modulus       <= '0;
      zero_flag     <= 1'b0;
      negative_flag <= 1'b0;
      overflow_flag <= 1'b0;
      carry_flag    <= 1'b0;
    end else begin
      if (accept && !div_zero && !sgn_ovf) begin
        work_q  <= dvd_abs;
        dvs_mag <= dvs_abs;
        rem     <= '0;
        cnt     <= '0;
        q_neg   <= signed_mode && (dividend[N-1] ^ divisor[N-1]);
        r_neg   <= signed_mode && dividend[N-1];
        sm_r    <= signed_mode;
      end else if (state == CALC) begin
        rem    <= take ? diff[N-1:0] : rem_sh[N-1:0];
        work_q <= {work_q[N-2:0], take};
        cnt    <= cnt + 1'b1;
      end
      if (load) begin
        quotient      <= res_q;
        modulus       <= res_r;
        zero_flag     <= (res_r == '0);
        negative_flag <= res_sm && res_r[N-1];
        overflow_flag <= res_ovf;
        carry_flag    <= (res_q == '0) && !res_ovf;
      end
    end
  end

endmodule

// File: tb/tb_n_bit_seq_divmod.sv
// Randomized bench for n_bit_seq_divmod against an arithmetic reference model,
// with literal vectors that pin the model itself.
module tb_n_bit_seq_divmod;

  localparam int N = 8;

  logic         clk, rst_n, in_valid, in_ready, signed_mode, out_valid, out_ready;
  logic [N-1:0] dividend, divisor, quotient, modulus;
  logic         zero_flag, negative_flag, overflow_flag, carry_flag;

  n_bit_seq_divmod #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .signed_mode(signed_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .modulus(modulus),
    .zero_flag(zero_flag), .negative_flag(negative_flag),
    .overflow_flag(overflow_flag), .carry_flag(carry_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] q, r;
    logic       z, n, o, c;
    int         lat;
    bit         lit;
    logic [7:0] lq, lr;
    logic [3:0] lf;
    int         llat;
  } exp_t;

  bit         p_lit = 1'b0;
  logic [7:0] p_q, p_r;
  logic [3:0] p_f;
  int         p_lat;

  function automatic exp_t mk_exp(logic [7:0] a, logic [7:0] b, logic sm);
    exp_t e;
    int   sa, sb;
    e = '{default: 0};
    if (b == 8'h00) begin
      e.q = 8'hFF; e.r = a; e.o = 1'b1; e.lat = 1;
    end else if (sm && a == 8'h80 && b == 8'hFF) begin
      e.q = a; e.r = 8'h00; e.o = 1'b1; e.lat = 1;
    end else begin
      e.lat = N + 2;
      if (sm) begin
        sa = int'($signed(a));
        sb = int'($signed(b));
        e.q = 8'(sa / sb);
        e.r = 8'(sa % sb);
      end else begin
        e.q = a / b;
        e.r = a % b;
      end
    end
    e.z = (e.r == 8'h00);
    e.n = sm && e.r[7];
    e.c = (e.q == 8'h00) && !e.o;
    e.lit = p_lit; e.lq = p_q; e.lr = p_r; e.lf = p_f; e.llat = p_lat;
    return e;
  endfunction

  exp_t exq[$];
  int   cyc = 0, acc_cyc = 0;
  bit   busy = 1'b0;

  // Monitor: accept/handshake tracking, sampled at the edge itself.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      exq.delete();
      busy = 1'b0;
    end else begin
      cyc = cyc + 1;
      if (busy && out_valid && out_ready) begin
        void'(exq.pop_front());
        busy = 1'b0;
      end
      if (in_valid && in_ready) begin
        exq.push_back(mk_exp(dividend, divisor, signed_mode));
        busy    = 1'b1;
        acc_cyc = cyc - 1;
      end
    end
  end

  int   errors = 0, checks = 0;
  bit   seen = 1'b0, wd = 1'b0;
  exp_t cur;
  logic [19:0] got, want;

  // Compare process: every falling edge.
  initial forever begin
    @(negedge clk);
    got = {quotient, modulus, zero_flag, negative_flag, overflow_flag, carry_flag};
    if (!rst_n) begin
      checks++;
      if ({in_ready, out_valid, got} !== {1'b1, 1'b0, 20'h0}) begin
        errors++;
        $display("FAIL reset_state: got rdy=%b vld=%b res=%h want rdy=1 vld=0 res=00000",
                 in_ready, out_valid, got);
      end
      seen = 1'b0; wd = 1'b0;
    end else begin
      checks++;
      if (in_ready !== !busy) begin
        errors++;
        $display("FAIL in_ready: got %b want %b (cycle %0d)", in_ready, !busy, cyc);
      end
      if (!busy) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL spurious_out_valid: got %b want 0 (cycle %0d)", out_valid, cyc);
        end
        seen = 1'b0; wd = 1'b0;
      end else if (out_valid) begin
        cur  = exq[0];
        want = {cur.q, cur.r, cur.z, cur.n, cur.o, cur.c};
        if (!seen) begin
          checks++;
          if (cyc - acc_cyc != cur.lat) begin
            errors++;
            $display("FAIL latency: got %0d want %0d", cyc - acc_cyc, cur.lat);
          end
          if (cur.lit) begin
            checks++;
            if (want !== {cur.lq, cur.lr, cur.lf}) begin
              errors++;
              $display("FAIL model_pin: got %h want %h", want, {cur.lq, cur.lr, cur.lf});
            end
            checks++;
            if (cyc - acc_cyc != cur.llat) begin
              errors++;
              $display("FAIL literal_latency: got %0d want %0d", cyc - acc_cyc, cur.llat);
            end
          end
          seen = 1'b1;
        end
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL result: got q=%h r=%h znoc=%b want q=%h r=%h znoc=%b",
                   got[19:12], got[11:4], got[3:0], want[19:12], want[11:4], want[3:0]);
        end
      end else if (!wd && (cyc - acc_cyc > N + 4)) begin
        checks++;
        errors++;
        wd = 1'b1;
        $display("FAIL timeout: got no out_valid after %0d edges want %0d", cyc - acc_cyc, N + 2);
      end
    end
  end

  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic sm, input int hold);
    int k;
    dividend = a; divisor = b; signed_mode = sm; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    dividend = 8'($urandom); divisor = 8'($urandom); signed_mode = 1'($urandom);
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!out_valid) begin
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end
    repeat (hold) begin
      in_valid = 1'($urandom);
      dividend = 8'($urandom);
      @(negedge clk);
    end
    out_ready = 1'b1;
    in_valid  = 1'($urandom);
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b0;
  endtask

  task automatic do_lit(input logic [7:0] a, input logic [7:0] b, input logic sm, input int hold,
                        input logic [7:0] lq, input logic [7:0] lr, input logic [3:0] lf,
                        input int llat);
    p_lit = 1'b1; p_q = lq; p_r = lr; p_f = lf; p_lat = llat;
    do_op(a, b, sm, hold);
    p_lit = 1'b0;
  endtask

  initial begin
    logic [7:0] a, b;
    int         r;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    dividend = '0; divisor = '0; signed_mode = 1'b0;
    p_q = '0; p_r = '0; p_f = '0; p_lat = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Flags packed as {zero, negative, overflow, carry}.
    do_lit(8'd17,  8'd5,   1'b0, 0, 8'h03, 8'h02, 4'b0000, 10);
    do_lit(8'hF9,  8'h02,  1'b1, 1, 8'hFD, 8'hFF, 4'b0100, 10);
    do_lit(8'h2A,  8'h00,  1'b0, 0, 8'hFF, 8'h2A, 4'b0010, 1);
    do_lit(8'h2A,  8'h00,  1'b1, 2, 8'hFF, 8'h2A, 4'b0010, 1);
    do_lit(8'h80,  8'hFF,  1'b1, 0, 8'h80, 8'h00, 4'b1010, 1);
    do_lit(8'd3,   8'd9,   1'b0, 5, 8'h00, 8'h03, 4'b0001, 10);

    // Abort mid-CALC: reset lands in the 4th CALC cycle.
    dividend = 8'd100; divisor = 8'd3; signed_mode = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    do_lit(8'd200, 8'd7,   1'b0, 0, 8'h1C, 8'h04, 4'b0000, 10);

    for (int i = 0; i < 80; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      r = $urandom_range(0, 7);
      if (r == 0) b = 8'h00;
      else if (r == 1) begin a = 8'h80; b = 8'hFF; end
      else if (r == 2) b = 8'($urandom_range(1, 3));
      do_op(a, b, 1'($urandom), $urandom_range(0, 3));
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
